// File: rtl/spi_rx_fifo.sv
// Oversampled serial word receiver with a show-ahead FIFO.
// Adds sticky overflow and one-cycle frame-error reporting.
module spi_rx_fifo #(
    parameter int WORD_W      = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter bit LSB_FIRST   = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              spi_clk,
    input  logic                              spi_fs,
    input  logic                              spi_data,
    input  logic                              read,
    input  logic                              test_mode,
    output logic [WORD_W-1:0]                 dout,
    output logic                              dflag,
    output logic                              full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
    output logic                              overflow,
    output logic                              frame_err
);

    localparam int CW = $clog2(WORD_W + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);
    localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        SHIFT  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] fs_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   s_clk;
    logic                   s_fs;
    logic                   s_data;
    logic                   s_clk_d;
    logic                   sclk_rise;

    state_t                 state;
    state_t                 state_n;
    logic                   clr_cnt;
    logic                   shift_en;
    logic                   abort;
    logic                   push;
    logic [CW-1:0]          bit_cnt;
    logic [WORD_W-1:0]      sr;

    logic [WORD_W-1:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [LW-1:0]          count;
    logic [WORD_W-1:0]      last_q;
    logic                   pop;
    logic                   accept;
    logic                   drop;

    assign s_clk     = clk_sync[SYNC_STAGES-1];
    assign s_fs      = fs_sync[SYNC_STAGES-1];
    assign s_data    = data_sync[SYNC_STAGES-1];
    assign sclk_rise = s_clk & ~s_clk_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= '0;
            fs_sync   <= '0;
            data_sync <= '0;
            s_clk_d   <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
            fs_sync   <= {fs_sync[SYNC_STAGES-2:0], spi_fs};
            data_sync <= {data_sync[SYNC_STAGES-2:0], spi_data};
            s_clk_d   <= s_clk;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        clr_cnt  = 1'b0;
        shift_en = 1'b0;
        abort    = 1'b0;
        push     = 1'b0;
        case (state)
            IDLE: begin
                if (s_fs && !s_clk) begin
                    state_n = ARM;
                    clr_cnt = 1'b1;
                end
            end
            ARM: begin
                if (!s_fs) begin
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                // A new sync mid-word restarts framing from ARM.
                if (s_fs) begin
                    abort   = 1'b1;
                    clr_cnt = 1'b1;
                    state_n = ARM;
                end else if (sclk_rise) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_n = COMMIT;
                    end
                end
            end
            COMMIT: begin
                push    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt   <= '0;
            sr        <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= abort;
            if (clr_cnt) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (shift_en) begin
                if (LSB_FIRST) begin
                    sr <= {s_data, sr[WORD_W-1:1]};
                end else begin
                    sr <= {sr[WORD_W-2:0], s_data};
                end
            end
        end
    end

    assign dflag  = (count != '0);
    assign full   = (count == DEPTH_L);
    assign level  = count;
    assign pop    = read & dflag & ~test_mode;
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;
    // last_q keeps the most recent head so dout holds once drained.
    assign dout   = dflag ? mem[rd_ptr] : last_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= sr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_q   <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
            if (dflag) begin
                last_q <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: doc/spi_rx_fifo.md
Name: spi_rx_fifo

Overview:
- Parametrised successor to the single-byte serial port receiver.
- Oversamples a slow serial port (serial clock, frame sync, data) entirely in the system `clk` domain.
- Assembles words of `WORD_W` bits, MSB-first or LSB-first, and buffers them in a `FIFO_DEPTH`-entry show-ahead FIFO.
- Sits between the external serial pins and the system bus reader; adds overflow and frame-error reporting.

Parameters:
- `WORD_W`, 8, bits per serial word (range 2..32).
- `FIFO_DEPTH`, 4, FIFO entries (power of 2, range 2..16).
- `LSB_FIRST`, 0, 0 = first serial bit lands in `dout[WORD_W-1]`; 1 = first bit lands in `dout[0]`.
- `SYNC_STAGES`, 2, synchroniser flops on `spi_clk`, `spi_fs` and `spi_data` (range 2..3).

Ports:
- `clk`, in, 1, system clock.
- `reset`, in, 1, synchronous active-high reset.
- `spi_clk`, in, 1, serial port clock (asynchronous to `clk`).
- `spi_fs`, in, 1, serial frame sync pulse.
- `spi_data`, in, 1, serial data.
- `read`, in, 1, pops the FIFO head.
- `test_mode`, in, 1, scan/test mode; blocks pops.
- `dout`, out, `WORD_W`, FIFO head word (show-ahead).
- `dflag`, out, 1, FIFO not empty.
- `full`, out, 1, FIFO holds `FIFO_DEPTH` words.
- `level`, out, `$clog2(FIFO_DEPTH+1)`, FIFO occupancy.
- `overflow`, out, 1, sticky; a word was dropped.
- `frame_err`, out, 1, one-cycle pulse; a word was aborted.

Behaviour:
- **Reset values.** While `reset` is sampled high at a `clk` edge:
  - state is IDLE and bit count is 0;
  - FIFO is emptied: `dflag`=0, `full`=0, `level`=0, `dout`=0;
  - `overflow`=0, `frame_err`=0;
  - synchroniser flops are cleared.
  - Reset asserted mid-word discards the partial word and all FIFO contents.
- **Input sampling.**
  - `spi_clk`, `spi_fs` and `spi_data` each pass through `SYNC_STAGES` flops.
  - `sclk_rise` = synchronised `spi_clk` is 1 now and was 0 in the previous registered sample.
  - Minimum legal serial timing: `spi_clk` high and low phases each ≥ `SYNC_STAGES`+1 `clk` periods.
- **State machine** (s = synchronised signals):
  - IDLE: `s_fs`=1 and `s_clk`=0 → ARM, clear bit count.
  - ARM: `s_fs`=0 → SHIFT. Any `sclk_rise` while in ARM is ignored.
  - SHIFT: on `sclk_rise`, shift in `s_data` and increment bit count. When the count reaches `WORD_W` → COMMIT.
  - SHIFT with `s_fs`=1 before the count reaches `WORD_W` → `frame_err` pulses for 1 cycle, the partial word is discarded, bit count clears, next state ARM.
  - COMMIT (one cycle): push the word to the FIFO, then → IDLE.
  - Unused encodings → IDLE.
- **Shift direction.**
  - `LSB_FIRST`=0: `sr <= {sr[WORD_W-2:0], s_data}`.
  - `LSB_FIRST`=1: `sr <= {s_data, sr[WORD_W-1:1]}`.
- **Latency.** The final `sclk_rise` occurs in cycle N. The state is COMMIT in cycle N+1. `dflag`/`dout`/`level` reflect the new word in cycle N+2 (when the FIFO was empty).
- **FIFO.**
  - Show-ahead: `dout` always equals the head entry, and holds its last value when empty.
  - A pop occurs when `read`=1, `dflag`=1 and `test_mode`=0.
  - `read` while empty: ignored.
  - `read` while `test_mode`=1: ignored and state is unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - `level` is 0..`FIFO_DEPTH`; `full` = (`level`==`FIFO_DEPTH`).
- **Simultaneous push and pop.**
  - Not full: both occur and `level` is unchanged.
  - Full: the pop frees the slot, the push is accepted, and `overflow` is not set.
- **Overflow.** COMMIT while `full`=1 with no pop in the same cycle:
  - the new word is dropped and FIFO contents are unchanged;
  - `overflow` is set and held until `reset`.

Test Plan:
- **MSB-first word, one frame.** Reset, `WORD_W`=8, `LSB_FIRST`=0; send `0xA5` → `dflag`=1 and `dout`=`0xA5` two `clk` cycles after the 8th detected `sclk_rise`; `level`=1; then `read` → `dflag`=0, `level`=0.
- **LSB-first ordering.** `LSB_FIRST`=1; send serial bits 1,0,1,0,0,1,0,1 → `dout`=`0xA5`.
- **Fill and overflow.** `FIFO_DEPTH`=4; send `0x11`,`0x22`,`0x33`,`0x44`,`0x55` without reading → `full`=1, `level`=4, `overflow`=1; successive pops yield `0x11`,`0x22`,`0x33`,`0x44`, then `dflag`=0.
- **Push and pop in the same cycle when full.** With 4 words queued, assert `read` in the COMMIT cycle of `0x66` → `overflow` stays 0, `level` stays 4, and the tail entry is `0x66`.
- **Frame error.** Assert `spi_fs` after 5 bits → one-cycle `frame_err`, no push; the following full `0x3C` frame is received correctly.
- **Test mode and mid-word reset.**
  - `test_mode`=1 with `read` pulsed → `level` and `dout` unchanged.
  - `reset` after 3 bits of a word → all outputs return to reset values; the next full frame `0xF0` is received correctly.
